// File: rtl/main_memory_responder.sv
// Main-memory responder: posted write buffer draining to a word RAM after WRITE_LAT
// cycles, combinational reads with youngest-entry forwarding, and traffic counters.
module main_memory_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned WB_DEPTH  = 4,
  parameter int unsigned WRITE_LAT = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            mem_req,
  input  logic                            mem_write,
  input  logic [31:0]                     mem_addr,
  input  logic [31:0]                     mem_write_data,
  output logic [31:0]                     mem_read_data,
  output logic [$clog2(WB_DEPTH+1)-1:0]   wb_count,
  output logic                            wb_full,
  output logic                            wb_empty,
  output logic                            drain_busy,
  output logic                            overflow,
  output logic [31:0]                     read_count,
  output logic [31:0]                     write_count,
  output logic [31:0]                     fwd_count
);

  localparam int unsigned CNT_W     = $clog2(WB_DEPTH + 1);
  localparam int unsigned PTR_W     = $clog2(WB_DEPTH);
  localparam int unsigned LAT_W     = (WRITE_LAT > 1) ? $clog2(WRITE_LAT) : 1;
  localparam int unsigned RAM_WORDS = 1 << ADDR_W;

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t              state;
  logic [LAT_W-1:0]    lat_cnt;
  logic [PTR_W-1:0]    head, tail;
  logic [ADDR_W-1:0]   wb_idx  [WB_DEPTH];
  logic [31:0]         wb_data [WB_DEPTH];
  logic [31:0]         ram     [RAM_WORDS];

  logic [ADDR_W-1:0]   idx;
  logic                rd_req, wr_req, pop, push_ok;
  logic                fwd_hit;
  logic [31:0]         fwd_data;
  logic [PTR_W:0]      pos;
  logic                unused_addr_bits;

  assign idx              = mem_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
  assign rd_req           = mem_req & ~mem_write;
  assign wr_req           = mem_req & mem_write;
  assign pop              = (state == COMMIT) && (lat_cnt == LAT_W'(WRITE_LAT - 1));
  assign push_ok          = wr_req && ((wb_count < CNT_W'(WB_DEPTH)) || pop);

  assign wb_full    = (wb_count == CNT_W'(WB_DEPTH));
  assign wb_empty   = (wb_count == '0);
  assign drain_busy = (state == COMMIT);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Walk oldest to youngest so the last match wins; the committing head stays visible.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    pos      = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      pos = {1'b0, head} + (PTR_W+1)'(i);
      if (pos >= (PTR_W+1)'(WB_DEPTH))
        pos = pos - (PTR_W+1)'(WB_DEPTH);
      if ((CNT_W'(i) < wb_count) && (wb_idx[pos[PTR_W-1:0]] == idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[pos[PTR_W-1:0]];
      end
    end
  end

  always_comb begin
    mem_read_data = '0;
    if (rd_req)
      mem_read_data = fwd_hit ? fwd_data : ram[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RAM_WORDS; i++)
        ram[ADDR_W'(i)] <= '0;
      state       <= IDLE;
      lat_cnt     <= '0;
      head        <= '0;
      tail        <= '0;
      wb_count    <= '0;
      overflow    <= 1'b0;
      read_count  <= '0;
      write_count <= '0;
      fwd_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          lat_cnt <= '0;
          if (wb_count != '0)
            state <= COMMIT;
        end
        COMMIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (pop) begin
            ram[wb_idx[head]] <= wb_data[head];
            head              <= next_ptr(head);
            lat_cnt           <= '0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (push_ok) begin
        wb_idx[tail]  <= idx;
        wb_data[tail] <= mem_write_data;
        tail          <= next_ptr(tail);
        write_count   <= write_count + 32'd1;
      end
      if (wr_req && !push_ok)
        overflow <= 1'b1;

      wb_count <= wb_count + CNT_W'(push_ok) - CNT_W'(pop);

      if (rd_req) begin
        read_count <= read_count + 32'd1;
        if (fwd_hit)
          fwd_count <= fwd_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: directed vector table, hand-written corner
// sequences and random traffic, all checked against a queue/timestamp model.
module tb_main_memory_responder;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned WB_DEPTH  = 4;
  localparam int unsigned WRITE_LAT = 3;

  logic        clk = 1'b0;
  logic        reset, mem_req, mem_write;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [2:0]  wb_count;
  logic        wb_full, wb_empty, drain_busy, overflow;
  logic [31:0] read_count, write_count, fwd_count;

  main_memory_responder #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH), .WRITE_LAT(WRITE_LAT)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .wb_count(wb_count), .wb_full(wb_full), .wb_empty(wb_empty), .drain_busy(drain_busy),
    .overflow(overflow), .read_count(read_count), .write_count(write_count),
    .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending writes in arrival order, plus the edge at which the
  // current head started its commit window (-1 when no commit is in progress).
  typedef struct { int unsigned idx; logic [31:0] data; } ent_t;
  ent_t        q[$];
  logic [31:0] m_ram [1 << ADDR_W];
  int          m_start, m_edge;
  logic [31:0] m_rc, m_wc, m_fc;
  bit          m_ovf;

  typedef struct {
    bit req; bit wr; logic [31:0] addr; logic [31:0] data;
    logic [31:0] exp_rd; int exp_cnt; bit exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) m_ram[i] = '0;
    m_start = -1;
    m_rc = 0; m_wc = 0; m_fc = 0; m_ovf = 0;
  endtask

  task automatic check_status();
    chk("wb_count",    32'(wb_count),   32'(q.size()));
    chk("wb_full",     32'(wb_full),    32'(q.size() == WB_DEPTH));
    chk("wb_empty",    32'(wb_empty),   32'(q.size() == 0));
    chk("drain_busy",  32'(drain_busy), 32'(m_start >= 0));
    chk("overflow",    32'(overflow),   32'(m_ovf));
    chk("read_count",  read_count,      m_rc);
    chk("write_count", write_count,     m_wc);
    chk("fwd_count",   fwd_count,       m_fc);
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_req = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_write_data = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_status();
    chk("rst_wb_count", 32'(wb_count), 32'd0);
    chk("rst_empty",    32'(wb_empty), 32'd1);
    chk("rst_rd_data",  mem_read_data, 32'd0);
    chk("rst_counters", read_count | write_count | fwd_count, 32'd0);
  endtask

  // One cycle of traffic; returns the combinational read data seen before the edge.
  task automatic step(input bit req, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, output logic [31:0] rd_seen);
    logic [31:0] exp;
    bit hit, pop, acc, nonempty;
    int unsigned idx;
    mem_req = req; mem_write = wr; mem_addr = addr; mem_write_data = data;
    idx = int'(addr[ADDR_W+1:2]);
    exp = '0; hit = 0;
    if (req && !wr) begin
      exp = m_ram[idx];
      foreach (q[k]) if (q[k].idx == idx) begin exp = q[k].data; hit = 1; end
    end
    #2;
    rd_seen = mem_read_data;
    chk("rd_data", mem_read_data, exp);
    @(posedge clk);
    if (req && !wr) begin m_rc++; if (hit) m_fc++; end
    pop      = (m_start >= 0) && (m_edge == m_start + int'(WRITE_LAT));
    nonempty = q.size() > 0;
    acc      = req && wr && (q.size() < WB_DEPTH || pop);
    if (req && wr && !acc) m_ovf = 1;
    if (pop) begin
      m_ram[q[0].idx] = q[0].data;
      void'(q.pop_front());
      m_start = -1;
    end else if (m_start < 0 && nonempty) begin
      m_start = m_edge;
    end
    if (acc) begin q.push_back('{idx, data}); m_wc++; end
    m_edge++;
    #1;
    mem_req = 1'b0; mem_write = 1'b0;
    check_status();
  endtask

  task automatic drain();
    logic [31:0] rd;
    for (int k = 0; k < 40 && !wb_empty; k++) step(0, 0, '0, '0, rd);
    chk("drain_done", 32'(wb_empty), 32'd1);
  endtask

  vec_t        vecs[$];
  logic [31:0] rd;

  initial begin
    m_edge = 0;
    model_reset();
    do_reset();

    vecs = '{
      '{1, 0, 32'h40, 32'h0,        32'h0,        0, 0},
      '{1, 1, 32'h40, 32'hDEADBEEF, 32'h0,        1, 0},
      '{1, 0, 32'h40, 32'h0,        32'hDEADBEEF, 1, 0},
      '{0, 0, 32'h0,  32'h0,        32'h0,        1, 0},
      '{0, 0, 32'h0,  32'h0,        32'h0,        1, 0},
      '{0, 0, 32'h0,  32'h0,        32'h0,        0, 0},
      '{1, 0, 32'h40, 32'h0,        32'hDEADBEEF, 0, 0},
      '{1, 1, 32'h80, 32'h1111,     32'h0,        1, 0},
      '{1, 1, 32'h80, 32'h2222,     32'h0,        2, 0},
      '{1, 0, 32'h80, 32'h0,        32'h2222,     2, 0},
      '{0, 0, 32'h0,  32'h0,        32'h0,        2, 0},
      '{0, 0, 32'h0,  32'h0,        32'h0,        1, 0},
      '{0, 0, 32'h0,  32'h0,        32'h0,        1, 0},
      '{0, 0, 32'h0,  32'h0,        32'h0,        1, 0},
      '{0, 0, 32'h0,  32'h0,        32'h0,        1, 0},
      '{0, 0, 32'h0,  32'h0,        32'h0,        0, 0},
      '{1, 0, 32'h80, 32'h0,        32'h2222,     0, 0}
    };
    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].data, rd);
      chk($sformatf("vec%0d_rd", i),  rd,                vecs[i].exp_rd);
      chk($sformatf("vec%0d_cnt", i), 32'(wb_count),     32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow),     32'(vecs[i].exp_ovf));
    end
    chk("tbl_read_count",  read_count,  32'd5);
    chk("tbl_fwd_count",   fwd_count,   32'd2);
    chk("tbl_write_count", write_count, 32'd3);

    // Six back-to-back writes into an empty, idle buffer: fifth rides the pop, sixth drops.
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 32'h100 + 32'(4 * k), 32'(k + 1), rd);
      chk($sformatf("burst%0d_cnt", k), 32'(wb_count), (k < 3) ? 32'(k + 1) : 32'd4);
      chk($sformatf("burst%0d_ovf", k), 32'(overflow), (k == 5) ? 32'd1 : 32'd0);
    end
    chk("burst_write_count", write_count, 32'd8);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    step(1, 0, 32'h110, '0, rd); chk("burst_w5_ram", rd, 32'd5);
    step(1, 0, 32'h114, '0, rd); chk("burst_w6_lost", rd, 32'd0);

    // Upper address bits are ignored.
    step(1, 1, 32'h0000_1004, 32'hA5A5A5A5, rd);
    drain();
    step(1, 0, 32'h0000_0004, '0, rd); chk("alias_rd", rd, 32'hA5A5A5A5);

    // Reset while a commit is in flight with three entries queued.
    step(1, 1, 32'h200, 32'h11, rd);
    step(1, 1, 32'h204, 32'h22, rd);
    step(1, 1, 32'h208, 32'h33, rd);
    chk("mid_busy", 32'(drain_busy), 32'd1);
    chk("mid_cnt",  32'(wb_count),   32'd3);
    do_reset();
    chk("mid_rst_busy", 32'(drain_busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 32'h200 + 32'(4 * k), '0, rd);
      chk($sformatf("mid_rst_rd%0d", k), rd, 32'd0);
    end

    // Random traffic over a few word indices with random ignored address bits.
    for (int n = 0; n < 400; n++) begin
      bit r, w;
      r = ($urandom_range(0, 9) < 7);
      w = ($urandom_range(0, 9) < 4);
      step(r, w, $urandom & 32'hFFFF_F01F, $urandom, rd);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Main-memory model on the responder side of the cache's `mem_*` request interface. It services write-through and write-miss traffic through a posted write buffer that drains to a word-addressed RAM with configurable commit latency. It answers read requests combinationally in the same cycle, forwarding from the write buffer when an address hit exists. It sits below the L1 cache in the hierarchy and exposes buffer status and traffic counters for the performance testbenches.

## Interface
Parameters:
- `ADDR_W`, default 10: word-index width; RAM holds 2^ADDR_W 32-bit words.
- `WB_DEPTH`, default 4: write-buffer entries, ≥2.
- `WRITE_LAT`, default 3: cycles an entry spends in COMMIT before it is written to RAM, ≥1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `mem_req`, in, 1: request strobe, one cycle per request, no ready/ack.
- `mem_write`, in, 1: 1 = write, 0 = read; valid with `mem_req`.
- `mem_addr`, in, 32: byte address; word index = `mem_addr[ADDR_W+1:2]`, other bits ignored.
- `mem_write_data`, in, 32: write data.
- `mem_read_data`, out, 32: combinational read data.
- `wb_count`, out, $clog2(WB_DEPTH+1): occupied entries.
- `wb_full`, out, 1: `wb_count == WB_DEPTH`.
- `wb_empty`, out, 1: `wb_count == 0`.
- `drain_busy`, out, 1: drain FSM in COMMIT.
- `overflow`, out, 1: sticky; set when a write is dropped.
- `read_count`, out, 32: read requests serviced.
- `write_count`, out, 32: writes accepted into the buffer.
- `fwd_count`, out, 32: reads served from the buffer.

## Operation
- Write (`mem_req & mem_write`): push {word index, data} at the tail. The push is accepted if `wb_count < WB_DEPTH` or a pop occurs on the same edge. Otherwise the write is dropped, `overflow` is set, and `write_count` does not increment.
- Read (`mem_req & ~mem_write`): `mem_read_data` returns the data of the youngest valid buffer entry whose index matches. The head entry in COMMIT counts as valid. If no entry matches, it returns `ram[index]`. `read_count` increments; `fwd_count` increments when the read was forwarded.
- With no read request, `mem_read_data` = 0.
- Drain FSM:
  - IDLE: if `!wb_empty`, go to COMMIT with `lat_cnt = 0`.
  - COMMIT: `lat_cnt` increments each cycle. On the edge where `lat_cnt == WRITE_LAT-1`: `ram[head.index] <= head.data`, pop head, return to IDLE.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- Head and tail pointers wrap modulo WB_DEPTH.
- All counters wrap at 2^32. A read in the same cycle as a commit to the same index returns identical data from either source; the forward path is used and is counted.

## Timing
- Reset (synchronous): RAM cleared to 0, buffer emptied, FSM to IDLE, `lat_cnt` = 0.
- Outputs after reset: all counters = 0, `overflow` = 0, `wb_count` = 0, `wb_empty` = 1, `wb_full` = 0, `drain_busy` = 0, `mem_read_data` = 0.
- Reset mid-drain: the in-flight entry and all buffered entries are discarded; RAM is not written.
- Read latency: 0 cycles (combinational); the cache samples it on the same edge.
- Commit latency:
  - An entry pushed at edge N into an empty buffer with the FSM in IDLE enters COMMIT at edge N+1 and is written to RAM and popped at edge N+1+WRITE_LAT.
  - Sustained drain rate is one entry per WRITE_LAT+1 cycles.
- Status outputs are registered state and reflect the effect of the most recent edge.

## Test plan
- Reset, then read 0x0000_0040 → `mem_read_data` = 0, `read_count` = 1, `fwd_count` = 0.
- Write 0x0000_0040 = 0xDEADBEEF at edge 0, read 0x40 in the next cycle → 0xDEADBEEF, `fwd_count` = 1. At edge 4 (WRITE_LAT=3): `wb_empty` = 1. A later read of 0x40 → 0xDEADBEEF from RAM, `fwd_count` still 1.
- Back-to-back writes to 0x80 of 0x1111 then 0x2222, then read 0x80 → 0x2222. After drain, RAM word 0x20 = 0x2222 and `write_count` = 2.
- Six back-to-back writes at edges 0–5 (WB_DEPTH=4, WRITE_LAT=3):
  - Write 5 is accepted at edge 4 through the simultaneous pop.
  - Write 6 is dropped: `overflow` = 1, `write_count` = 5, `wb_count` = 4.
  - `overflow` stays 1 until reset.
- Aliasing: write 0x0000_1004 = 0xA5A5A5A5, drain, read 0x0000_0004 → 0xA5A5A5A5.
- Reset asserted while `drain_busy` = 1 with 3 entries buffered:
  - Next cycle: `wb_count` = 0, `drain_busy` = 0, all counters = 0.
  - Reads of all three addresses → 0.
